// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the MIPS fetch-stage PC sequencer: redirect source codes,
// FSM states and default vectors.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_JMP = 2'd1,
    SRC_BR  = 2'd2,
    SRC_EXC = 2'd3
  } redirect_src_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_t;

  localparam int unsigned DEF_NB_WIDTH     = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEF_PC_INC       = 4;
  localparam int unsigned DEF_RAS_DEPTH    = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Pipeline-facing bus of the PC sequencer. With PC_ALIGN_CHECK_EN defined the
// bus also carries the o_misalign trap pulse.
interface pc_sequencer_if #(
  parameter int unsigned NB_WIDTH = 32
);

  logic                i_stall;
  logic                i_halt;
  logic                i_resume;
  logic                i_exc_valid;
  logic                i_br_valid;
  logic [NB_WIDTH-1:0] i_br_addr;
  logic                i_jmp_valid;
  logic [NB_WIDTH-1:0] i_jmp_addr;
  logic                i_call;
  logic                i_ret;
  logic [NB_WIDTH-1:0] i_link_addr;
  logic [NB_WIDTH-1:0] o_pcounter;
  logic [NB_WIDTH-1:0] o_pcounter4;
  logic                o_redirect;
  logic [1:0]          o_redirect_src;
  logic                o_halted;
  logic                o_ras_empty;
  logic                o_ras_full;
`ifdef PC_ALIGN_CHECK_EN
  logic                o_misalign;
`endif

  modport master (
    output i_stall, i_halt, i_resume, i_exc_valid, i_br_valid, i_br_addr,
           i_jmp_valid, i_jmp_addr, i_call, i_ret, i_link_addr,
    input  o_pcounter, o_pcounter4, o_redirect, o_redirect_src, o_halted,
           o_ras_empty, o_ras_full
`ifdef PC_ALIGN_CHECK_EN
           , o_misalign
`endif
  );

  modport slave (
    input  i_stall, i_halt, i_resume, i_exc_valid, i_br_valid, i_br_addr,
           i_jmp_valid, i_jmp_addr, i_call, i_ret, i_link_addr,
    output o_pcounter, o_pcounter4, o_redirect, o_redirect_src, o_halted,
           o_ras_empty, o_ras_full
`ifdef PC_ALIGN_CHECK_EN
           , o_misalign
`endif
  );

endinterface

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack. When full, a push overwrites the oldest
// entry; a combined call+return replaces the top in place.
module pc_ras #(
  parameter int unsigned NB_WIDTH  = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                call,
  input  logic                ret,
  input  logic [NB_WIDTH-1:0] link,
  output logic [NB_WIDTH-1:0] top,
  output logic                empty,
  output logic                full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [NB_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    top_idx;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                pop;
  logic                replace;

  // ptr addresses the next free slot; the depth being a power of two makes it wrap naturally
  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RAS_DEPTH));

  assign push    = call & (~ret | empty);
  assign replace = call & ret & ~empty;
  assign pop     = ret & ~call & ~empty;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)         mem[ptr]     <= link;
    else if (replace) mem[top_idx] <= link;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: exception > branch > jump/return > sequential, with a
// sticky halt FSM and return-address stack. PC_ALIGN_CHECK_EN traps misaligned targets.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int unsigned          NB_WIDTH     = DEF_NB_WIDTH,
  parameter logic [NB_WIDTH-1:0]  RESET_VECTOR = NB_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [NB_WIDTH-1:0]  EXC_VECTOR   = NB_WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned          PC_INC       = DEF_PC_INC,
  parameter int unsigned          RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input logic           clk,
  input logic           i_rst_n,
  pc_sequencer_if.slave bus
);

  pc_state_t           state;
  pc_state_t           state_next;
  logic [NB_WIDTH-1:0] pc;
  logic [NB_WIDTH-1:0] pc4;
  logic [NB_WIDTH-1:0] pc_next;
  logic [NB_WIDTH-1:0] target;
  redirect_src_t       target_src;
  logic                take_target;
  redirect_src_t       src_next;
  redirect_src_t       src_q;
  logic                redirect_next;
  logic                redirect_q;
  logic                ras_en;
  logic [NB_WIDTH-1:0] ras_top;
  logic                ras_empty;
  logic                ras_full;
`ifdef PC_ALIGN_CHECK_EN
  logic                misalign_next;
  logic                misalign_q;
`endif

  assign pc4 = pc + NB_WIDTH'(PC_INC);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_RUN;
    else          state <= state_next;
  end

  // An exception being taken drops a concurrent halt request
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (!bus.i_exc_valid && bus.i_halt) state_next = ST_HALTED;
      ST_HALTED: if (bus.i_resume) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_next       = pc;
    src_next      = SRC_SEQ;
    redirect_next = 1'b0;
    ras_en        = 1'b0;
    target        = bus.i_br_addr;
    target_src    = SRC_BR;
    take_target   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_next = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if (bus.i_exc_valid) begin
          pc_next       = EXC_VECTOR;
          src_next      = SRC_EXC;
          redirect_next = 1'b1;
        end else if (bus.i_halt) begin
          pc_next = pc;
        end else if (bus.i_br_valid) begin
          take_target = 1'b1;
        end else if (bus.i_jmp_valid && !bus.i_stall) begin
          take_target = 1'b1;
          target_src  = SRC_JMP;
          target      = (bus.i_ret && !ras_empty) ? ras_top : bus.i_jmp_addr;
          ras_en      = 1'b1;
        end else if (!bus.i_stall) begin
          pc_next = pc4;
        end
      end
      ST_HALTED: if (bus.i_resume && !bus.i_stall) pc_next = pc4;
      default:   pc_next = pc;
    endcase
    if (take_target) begin
      pc_next       = target;
      src_next      = target_src;
      redirect_next = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      if (target[1:0] != 2'b00) begin
        pc_next       = EXC_VECTOR;
        src_next      = SRC_EXC;
        misalign_next = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc         <= RESET_VECTOR;
      src_q      <= SRC_SEQ;
      redirect_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc         <= pc_next;
      src_q      <= src_next;
      redirect_q <= redirect_next;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q <= misalign_next;
`endif
    end
  end

  pc_ras #(
    .NB_WIDTH  (NB_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .call    (ras_en & bus.i_call),
    .ret     (ras_en & bus.i_ret),
    .link    (bus.i_link_addr),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

  assign bus.o_pcounter     = pc;
  assign bus.o_pcounter4    = pc4;
  assign bus.o_redirect     = redirect_q;
  assign bus.o_redirect_src = src_q;
  assign bus.o_halted       = (state == ST_HALTED);
  assign bus.o_ras_empty    = ras_empty;
  assign bus.o_ras_full     = ras_full;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.o_misalign     = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; expectations follow PC_ALIGN_CHECK_EN
// when it is defined.
module tb_pc_sequencer;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        redirect;
    logic [1:0]  src;
    logic        halted;
    logic        empty;
    logic        full;
    logic        misalign;
  } exp_t;

  logic clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  pc_sequencer_if #(.NB_WIDTH(32)) bus ();

  pc_sequencer dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic stall, input logic halt, input logic resume,
                                input logic exc, input logic br, input logic [31:0] br_addr,
                                input logic jmp, input logic [31:0] jmp_addr,
                                input logic call, input logic ret, input logic [31:0] link);
    bus.i_stall     = stall;
    bus.i_halt      = halt;
    bus.i_resume    = resume;
    bus.i_exc_valid = exc;
    bus.i_br_valid  = br;
    bus.i_br_addr   = br_addr;
    bus.i_jmp_valid = jmp;
    bus.i_jmp_addr  = jmp_addr;
    bus.i_call      = call;
    bus.i_ret       = ret;
    bus.i_link_addr = link;
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic push_expect(input string tag, input logic [31:0] pc, input logic redirect,
                             input logic [1:0] src, input logic halted, input logic empty,
                             input logic full, input logic misalign);
    exp_t e;
    e.tag = tag; e.pc = pc; e.redirect = redirect; e.src = src;
    e.halted = halted; e.empty = empty; e.full = full; e.misalign = misalign;
    sb.push_back(e);
  endtask

  task automatic check_field(input string tag, input string field,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
    end
  endtask

  task automatic check_output();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_field(e.tag, "pc",       bus.o_pcounter,            e.pc);
      check_field(e.tag, "pc4",      bus.o_pcounter4,           e.pc + 32'd4);
      check_field(e.tag, "redirect", 32'(bus.o_redirect),       32'(e.redirect));
      check_field(e.tag, "src",      32'(bus.o_redirect_src),   32'(e.src));
      check_field(e.tag, "halted",   32'(bus.o_halted),         32'(e.halted));
      check_field(e.tag, "empty",    32'(bus.o_ras_empty),      32'(e.empty));
      check_field(e.tag, "full",     32'(bus.o_ras_full),       32'(e.full));
`ifdef PC_ALIGN_CHECK_EN
      check_field(e.tag, "misalign", 32'(bus.o_misalign),       32'(e.misalign));
`endif
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    idle();
    #1;
    push_expect("reset", 32'h0, 0, 0, 0, 1, 0, 0);
    check_output();
    @(negedge clk);
    i_rst_n = 1'b1;

    push_expect("seq1", 32'h4, 0, 0, 0, 1, 0, 0); advance();
    push_expect("seq2", 32'h8, 0, 0, 0, 1, 0, 0); advance();
    push_expect("seq3", 32'hC, 0, 0, 0, 1, 0, 0); advance();

    apply_stimulus(1, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0);
    push_expect("br_stall", 32'h100, 1, 2, 0, 1, 0, 0); advance();
    apply_stimulus(1, 0, 0, 0, 0, 32'h0, 1, 32'h200, 0, 0, 32'h0);
    push_expect("jmp_stall", 32'h100, 0, 0, 0, 1, 0, 0); advance();

    apply_stimulus(0, 0, 0, 1, 1, 32'h300, 1, 32'h200, 1, 0, 32'h999);
    push_expect("exc_prio", 32'h80, 1, 3, 0, 1, 0, 0); advance();

    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h1000, 1, 0, 32'(k * 16));
      push_expect($sformatf("call%0d", k), 32'h1000, 1, 1, 0, 0, (k >= 4), 0);
      advance();
    end
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h2000, 0, 1, 32'h0);
      push_expect($sformatf("ret%0d", k), 32'(96 - 16 * k), 1, 1, 0, (k == 4), 0, 0);
      advance();
    end
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h2000, 0, 1, 32'h0);
    push_expect("ret5_empty", 32'h2000, 1, 1, 0, 1, 0, 0); advance();

    apply_stimulus(0, 0, 0, 0, 1, 32'h102, 0, 32'h0, 0, 0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    push_expect("br_misalign", 32'h80, 1, 3, 0, 1, 0, 1); advance();
    idle();
    push_expect("after_misalign", 32'h84, 0, 0, 0, 1, 0, 0); advance();
`else
    push_expect("br_misalign", 32'h102, 1, 2, 0, 1, 0, 0); advance();
    idle();
    push_expect("after_misalign", 32'h106, 0, 0, 0, 1, 0, 0); advance();
`endif

    apply_stimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0);
    push_expect("br_top", 32'hFFFF_FFFC, 1, 2, 0, 1, 0, 0); advance();
    idle();
    push_expect("wrap", 32'h0, 0, 0, 0, 1, 0, 0); advance();

    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h400, 1, 1, 32'h44);
    push_expect("callret_empty", 32'h400, 1, 1, 0, 0, 0, 0); advance();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h500, 1, 1, 32'h88);
    push_expect("callret_top", 32'h44, 1, 1, 0, 0, 0, 0); advance();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h600, 0, 1, 32'h0);
    push_expect("ret_replaced", 32'h88, 1, 1, 0, 1, 0, 0); advance();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h700, 1, 0, 32'h70);
    push_expect("call_prereset", 32'h700, 1, 1, 0, 0, 0, 0); advance();

    i_rst_n = 1'b0;
    idle();
    #1;
    push_expect("mid_reset", 32'h0, 0, 0, 0, 1, 0, 0);
    check_output();
    @(negedge clk);
    i_rst_n = 1'b1;
    push_expect("post_reset1", 32'h4, 0, 0, 0, 1, 0, 0); advance();
    push_expect("post_reset2", 32'h8, 0, 0, 0, 1, 0, 0); advance();

    apply_stimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    push_expect("halt", 32'h8, 0, 0, 1, 1, 0, 0); advance();
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(0, 0, 0, (k == 9), (k % 2 == 1), 32'h500, 1, 32'h300, 1, 0, 32'h12);
      push_expect($sformatf("halted%0d", k), 32'h8, 0, 0, 1, 1, 0, 0);
      advance();
    end
    apply_stimulus(0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    push_expect("resume", 32'hC, 0, 0, 0, 1, 0, 0); advance();

    apply_stimulus(0, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    push_expect("exc_drops_halt", 32'h80, 1, 3, 0, 1, 0, 0); advance();
    apply_stimulus(0, 1, 0, 0, 1, 32'h400, 0, 32'h0, 0, 0, 32'h0);
    push_expect("halt_over_br", 32'h80, 0, 0, 1, 1, 0, 0); advance();
    apply_stimulus(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    push_expect("resume_wins", 32'h84, 0, 0, 0, 1, 0, 0); advance();
    apply_stimulus(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    push_expect("stall_hold", 32'h84, 0, 0, 0, 1, 0, 0); advance();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the MIPS fetch stage. It generates the fetch PC from four sources, in priority order: exception, EX-stage branch, ID-stage jump/return, sequential increment. It adds a configurable reset vector, a sticky halt/resume FSM, and a small return-address stack (RAS) for call/return prediction. A registered redirect indication tells the pipeline which source steered the PC.

Parameters:
NB_WIDTH, 32, PC/address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, exception handler address (also the misalignment trap target)
PC_INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_stall  in  1  hazard stall; freezes sequential and jump updates
i_halt  in  1  request to enter HALTED (sticky)
i_resume  in  1  leave HALTED
i_exc_valid  in  1  exception redirect to EXC_VECTOR
i_br_valid  in  1  EX-resolved branch taken
i_br_addr  in  NB_WIDTH  branch target
i_jmp_valid  in  1  ID-stage jump
i_jmp_addr  in  NB_WIDTH  jump target (fallback for return when RAS is empty)
i_call  in  1  qualifies jump as call: push i_link_addr
i_ret  in  1  qualifies jump as return: target is RAS top
i_link_addr  in  NB_WIDTH  return address to push
o_pcounter  out  NB_WIDTH  current fetch PC
o_pcounter4  out  NB_WIDTH  o_pcounter + PC_INC (combinational)
o_redirect  out  1  registered: PC was loaded from a redirect last edge
o_redirect_src  out  2  registered: 0 seq, 1 jump/ret, 2 branch, 3 exception
o_halted  out  1  FSM is in HALTED
o_ras_empty  out  1  RAS count == 0
o_ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (async, i_rst_n=0): o_pcounter=RESET_VECTOR, state RUN, o_redirect=0, o_redirect_src=0, RAS count=0, pointer=0, o_halted=0, o_ras_empty=1, o_ras_full=0. Reset mid-operation discards all state immediately.
- FSM has two states: RUN and HALTED.
  - RUN -> HALTED on i_halt, when no exception is being taken that cycle. The PC holds and nothing else is accepted that edge.
  - HALTED -> RUN on i_resume. The PC resumes from the held value on the next edge.
  - In HALTED, all redirect and RAS inputs are ignored. i_halt and i_resume together in HALTED: resume wins.
- PC update in RUN, one edge latency, one source per edge, first match wins:
  1. i_exc_valid -> EXC_VECTOR. Overrides stall and halt. The halt request is dropped.
  2. i_br_valid -> i_br_addr. Overrides stall.
  3. i_jmp_valid & !i_stall -> target:
     - RAS top if i_ret and RAS is non-empty;
     - otherwise i_jmp_addr.
  4. !i_stall -> o_pcounter + PC_INC.
  5. Otherwise hold.
- Arithmetic is NB_WIDTH modulo; wrap-around at 2^NB_WIDTH is silent.
- o_redirect/o_redirect_src are registered from the chosen source. They become valid in the same cycle the new PC appears. A hold or a sequential update gives o_redirect=0, src=0.
- RAS:
  - The RAS changes only when the jump source (3) is the chosen source.
  - Call pushes i_link_addr. When full, it overwrites the oldest entry (circular); count stays RAS_DEPTH.
  - Return with count>0 pops. Return with count 0 changes nothing.
  - i_call & i_ret together: the target is the RAS top (or i_jmp_addr if empty), then the top is replaced by i_link_addr; count is unchanged (or becomes 1 if it was empty).
  - A jump squashed by an exception or branch does not touch the RAS. Branch and exception flushes do not repair the RAS.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Any redirect target (branch, jump, RAS) with addr[1:0] != 0 is replaced by EXC_VECTOR; o_redirect_src = 3.
  - Output o_misalign (1 bit, registered, reset 0) pulses for one cycle with the new PC.
  - A misaligned call/return still performs its RAS update.
- Undefined: targets are loaded unchanged. The o_misalign port is absent.

Decomposition:
- Shared package mips_pc_pkg holds:
  - redirect source encodings SRC_SEQ=0, SRC_JMP=1, SRC_BR=2, SRC_EXC=3;
  - FSM state encodings ST_RUN, ST_HALTED;
  - the default vectors.
- One sub-module, pc_ras: a circular return-address stack with push/pop/top/empty/full, parametrised by NB_WIDTH and RAS_DEPTH.

Test Plan:
- Reset then 3 free-running edges -> o_pcounter 0x0, 0x4, 0x8, 0xC; o_redirect=0 throughout.
- Stall high with i_br_valid=1, i_br_addr=0x100 -> next PC 0x100, o_redirect=1, src=2; stall plus i_jmp_valid only -> PC holds.
- i_jmp_valid, i_br_valid and i_exc_valid all in one cycle -> PC=0x80, src=3, RAS unchanged even with i_call=1.
- 5 calls with link 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) -> o_ras_full=1; 4 returns yield 0x50, 0x40, 0x30, 0x20; a 5th return falls back to i_jmp_addr and o_ras_empty=1.
- i_halt at PC 0x8 -> o_halted=1 and PC frozen for 10 cycles despite jumps; i_resume -> PC 0xC next edge.
- With PC_ALIGN_CHECK_EN defined, branch to 0x102 -> PC=0x80, o_misalign pulse for 1 cycle; without the macro, PC=0x102.
